// File: rtl/jtag_tap_oversampled_pkg.sv
// Shared TAP definitions: 1149.1 state encoding, instruction opcodes,
// the IR capture pattern and the instruction-to-data-register decode.
// Optional feature macro: JTAG_TAP_USERCODE_EN (opcode 4'h3 selects USERCODE).
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'hF,
    RUN_TEST_IDLE    = 4'hC,
    SELECT_DR_SCAN   = 4'h7,
    CAPTURE_DR       = 4'h6,
    SHIFT_DR         = 4'h2,
    EXIT1_DR         = 4'h1,
    PAUSE_DR         = 4'h3,
    EXIT2_DR         = 4'h0,
    UPDATE_DR        = 4'h5,
    SELECT_IR_SCAN   = 4'h4,
    CAPTURE_IR       = 4'hE,
    SHIFT_IR         = 4'hA,
    EXIT1_IR         = 4'h9,
    PAUSE_IR         = 4'hB,
    EXIT2_IR         = 4'h8,
    UPDATE_IR        = 4'hD
  } tap_state_e;

  localparam logic [3:0] INSTR_EXTEST         = 4'h0;
  localparam logic [3:0] INSTR_SAMPLE_PRELOAD = 4'h1;
  localparam logic [3:0] INSTR_IDCODE         = 4'h2;
  localparam logic [3:0] INSTR_USERCODE       = 4'h3;
  localparam logic [3:0] INSTR_DEBUG          = 4'h8;
  localparam logic [3:0] INSTR_BYPASS         = 4'hF;

  // Fixed pattern loaded into the IR shift register in Capture-IR.
  localparam logic [3:0] IR_CAPTURE = 4'b0101;

  typedef enum logic [1:0] {
    DR_BYPASS   = 2'd0,
    DR_IDCODE   = 2'd1,
    DR_USERCODE = 2'd2,
    DR_DEBUG    = 2'd3
  } dr_sel_e;

  // Map an instruction to the data register it selects; anything without
  // a dedicated register (including EXTEST/SAMPLE_PRELOAD) is BYPASS.
  function automatic dr_sel_e decode_instr(input logic [3:0] ir);
    dr_sel_e sel;
    case (ir)
      INSTR_IDCODE:   sel = DR_IDCODE;
`ifdef JTAG_TAP_USERCODE_EN
      INSTR_USERCODE: sel = DR_USERCODE;
`endif
      INSTR_DEBUG:    sel = DR_DEBUG;
      default:        sel = DR_BYPASS;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/jtag_tap_oversampled_if.sv
// Pad-side and debug-side signals of the oversampled TAP. The TAP itself
// uses the slave modport; the pads/debug unit side uses master.
interface jtag_tap_oversampled_if;
  logic tck_pad_i;
  logic tms_pad_i;
  logic tdi_pad_i;
  logic tdo_pad_o;
  logic tdo_oe_o;
  logic test_logic_reset_o;
  logic debug_select_o;
  logic shift_dr_o;
  logic capture_dr_o;
  logic update_dr_o;
  logic pause_dr_o;
  logic debug_tdi_o;
  logic debug_tdo_i;

  modport slave (
    input  tck_pad_i, tms_pad_i, tdi_pad_i, debug_tdo_i,
    output tdo_pad_o, tdo_oe_o, test_logic_reset_o, debug_select_o,
           shift_dr_o, capture_dr_o, update_dr_o, pause_dr_o, debug_tdi_o
  );

  modport master (
    output tck_pad_i, tms_pad_i, tdi_pad_i, debug_tdo_i,
    input  tdo_pad_o, tdo_oe_o, test_logic_reset_o, debug_select_o,
           shift_dr_o, capture_dr_o, update_dr_o, pause_dr_o, debug_tdi_o
  );
endinterface

// File: rtl/jtag_tap_oversampled_pin_sync.sv
// Brings tck/tms/tdi into the system clock domain through equal-depth
// synchronisers so tms/tdi stay aligned with the detected tck edges.
module jtag_pin_sync (
  input  logic clk,
  input  logic rst,
  input  logic tck_pad,
  input  logic tms_pad,
  input  logic tdi_pad,
  output logic tck_rise,
  output logic tck_fall,
  output logic tms_s,
  output logic tdi_s
);

  logic [1:0] tck_sync_r;
  logic [1:0] tms_sync_r;
  logic [1:0] tdi_sync_r;
  logic       tck_d_r;

  // Two-flop synchronisers plus one tck history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      tck_sync_r <= 2'b00;
      tms_sync_r <= 2'b00;
      tdi_sync_r <= 2'b00;
      tck_d_r    <= 1'b0;
    end else begin
      tck_sync_r <= {tck_sync_r[0], tck_pad};
      tms_sync_r <= {tms_sync_r[0], tms_pad};
      tdi_sync_r <= {tdi_sync_r[0], tdi_pad};
      tck_d_r    <= tck_sync_r[1];
    end
  end

  assign tck_rise = tck_sync_r[1] & ~tck_d_r;
  assign tck_fall = ~tck_sync_r[1] & tck_d_r;
  assign tms_s    = tms_sync_r[1];
  assign tdi_s    = tdi_sync_r[1];

endmodule

// File: rtl/jtag_tap_oversampled.sv
// IEEE 1149.1 TAP responder running entirely in the wb_clk_i domain.
// tck is oversampled; every register update happens on a detected tck edge.
// Optional feature macro: JTAG_TAP_USERCODE_EN adds the USERCODE register.
module jtag_tap_oversampled
  import jtag_tap_pkg::*;
#(
  parameter int unsigned IR_WIDTH       = 4,
  parameter logic [31:0] IDCODE_VALUE   = 32'h149511C3,
  parameter logic [31:0] USERCODE_VALUE = 32'h00000000
) (
  input logic                   wb_clk_i,
  input logic                   wb_rst_i,
  jtag_tap_oversampled_if.slave tap
);

  logic                tck_rise_s, tck_fall_s, tms_s, tdi_s;
  tap_state_e          state_r, state_next_s;
  logic [IR_WIDTH-1:0] ir_r, ir_next_s, ir_shift_r;
  logic [31:0]         dr_shift_r;
  logic                bypass_r;
  dr_sel_e             dr_sel_s;
  logic                tdo_r, tdo_oe_r, tlr_r, debug_select_r;
  logic                shift_dr_r, capture_dr_r, update_dr_r, pause_dr_r, debug_tdi_r;

  jtag_pin_sync u_pin_sync (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .tck_pad  (tap.tck_pad_i),
    .tms_pad  (tap.tms_pad_i),
    .tdi_pad  (tap.tdi_pad_i),
    .tck_rise (tck_rise_s),
    .tck_fall (tck_fall_s),
    .tms_s    (tms_s),
    .tdi_s    (tdi_s)
  );

`ifdef JTAG_TAP_USERCODE_EN
`else
  logic unused_usercode_s;
  assign unused_usercode_s = ^USERCODE_VALUE;
`endif

  assign dr_sel_s = decode_instr(4'(ir_r));

  // TAP state register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_r <= TEST_LOGIC_RESET;
    else          state_r <= state_next_s;
  end

  // Standard 1149.1 transitions, taken only on a tck rise.
  always_comb begin
    state_next_s = state_r;
    if (tck_rise_s) begin
      case (state_r)
        TEST_LOGIC_RESET: state_next_s = tms_s ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
        RUN_TEST_IDLE:    state_next_s = tms_s ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
        SELECT_DR_SCAN:   state_next_s = tms_s ? SELECT_IR_SCAN   : CAPTURE_DR;
        CAPTURE_DR:       state_next_s = tms_s ? EXIT1_DR         : SHIFT_DR;
        SHIFT_DR:         state_next_s = tms_s ? EXIT1_DR         : SHIFT_DR;
        EXIT1_DR:         state_next_s = tms_s ? UPDATE_DR        : PAUSE_DR;
        PAUSE_DR:         state_next_s = tms_s ? EXIT2_DR         : PAUSE_DR;
        EXIT2_DR:         state_next_s = tms_s ? UPDATE_DR        : SHIFT_DR;
        UPDATE_DR:        state_next_s = tms_s ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
        SELECT_IR_SCAN:   state_next_s = tms_s ? TEST_LOGIC_RESET : CAPTURE_IR;
        CAPTURE_IR:       state_next_s = tms_s ? EXIT1_IR         : SHIFT_IR;
        SHIFT_IR:         state_next_s = tms_s ? EXIT1_IR         : SHIFT_IR;
        EXIT1_IR:         state_next_s = tms_s ? UPDATE_IR        : PAUSE_IR;
        PAUSE_IR:         state_next_s = tms_s ? EXIT2_IR         : PAUSE_IR;
        EXIT2_IR:         state_next_s = tms_s ? UPDATE_IR        : SHIFT_IR;
        UPDATE_IR:        state_next_s = tms_s ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
        default:          state_next_s = TEST_LOGIC_RESET;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // IR returns to IDCODE whenever the FSM enters Test-Logic-Reset.
  always_comb begin
    ir_next_s = ir_r;
    if (tck_rise_s && state_next_s == TEST_LOGIC_RESET) begin
      ir_next_s = IR_WIDTH'(INSTR_IDCODE);
    end else if (tck_rise_s && state_r == UPDATE_IR) begin
      ir_next_s = ir_shift_r;
    end else begin
      ir_next_s = ir_r;
    end
  end

  // Instruction register and its DEBUG decode, updated together.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ir_r           <= IR_WIDTH'(INSTR_IDCODE);
      debug_select_r <= 1'b0;
    end else begin
      ir_r           <= ir_next_s;
      debug_select_r <= (4'(ir_next_s) == INSTR_DEBUG);
    end
  end

  // IR shift register: capture pattern, then shift right with TDI at the MSB.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ir_shift_r <= '0;
    end else if (tck_rise_s) begin
      case (state_r)
        CAPTURE_IR: ir_shift_r <= IR_WIDTH'(IR_CAPTURE);
        SHIFT_IR:   ir_shift_r <= {tdi_s, ir_shift_r[IR_WIDTH-1:1]};
        default:    ir_shift_r <= ir_shift_r;
      endcase
    end
  end

  // Data registers; DEBUG leaves capture/shift to the debug unit.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      dr_shift_r <= 32'h0000_0000;
      bypass_r   <= 1'b0;
    end else if (tck_rise_s && state_r == CAPTURE_DR) begin
      case (dr_sel_s)
        DR_IDCODE:   dr_shift_r <= IDCODE_VALUE;
`ifdef JTAG_TAP_USERCODE_EN
        DR_USERCODE: dr_shift_r <= USERCODE_VALUE;
`endif
        DR_DEBUG:    dr_shift_r <= dr_shift_r;
        default:     bypass_r   <= 1'b0;
      endcase
    end else if (tck_rise_s && state_r == SHIFT_DR) begin
      case (dr_sel_s)
        DR_IDCODE, DR_USERCODE: dr_shift_r <= {tdi_s, dr_shift_r[31:1]};
        DR_DEBUG:               dr_shift_r <= dr_shift_r;
        default:                bypass_r   <= tdi_s;
      endcase
    end
  end

  // TDO and its enable change on tck fall; TDO holds outside shift states.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tdo_r    <= 1'b0;
      tdo_oe_r <= 1'b0;
    end else if (tck_fall_s) begin
      case (state_r)
        SHIFT_IR: begin
          tdo_r    <= ir_shift_r[0];
          tdo_oe_r <= 1'b1;
        end
        SHIFT_DR: begin
          case (dr_sel_s)
            DR_DEBUG:               tdo_r <= tap.debug_tdo_i;
            DR_IDCODE, DR_USERCODE: tdo_r <= dr_shift_r[0];
            default:                tdo_r <= bypass_r;
          endcase
          tdo_oe_r <= 1'b1;
        end
        default: tdo_oe_r <= 1'b0;
      endcase
    end
  end

  // One-cycle strobes for the rise processed in each state, plus state flags.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      shift_dr_r   <= 1'b0;
      capture_dr_r <= 1'b0;
      update_dr_r  <= 1'b0;
      debug_tdi_r  <= 1'b0;
      tlr_r        <= 1'b1;
      pause_dr_r   <= 1'b0;
    end else begin
      shift_dr_r   <= tck_rise_s && (state_r == SHIFT_DR);
      capture_dr_r <= tck_rise_s && (state_r == CAPTURE_DR);
      update_dr_r  <= tck_rise_s && (state_r == UPDATE_DR);
      if (tck_rise_s && state_r == SHIFT_DR) debug_tdi_r <= tdi_s;
      tlr_r        <= (state_next_s == TEST_LOGIC_RESET);
      pause_dr_r   <= (state_next_s == PAUSE_DR);
    end
  end

  assign tap.tdo_pad_o          = tdo_r;
  assign tap.tdo_oe_o           = tdo_oe_r;
  assign tap.test_logic_reset_o = tlr_r;
  assign tap.debug_select_o     = debug_select_r;
  assign tap.shift_dr_o         = shift_dr_r;
  assign tap.capture_dr_o       = capture_dr_r;
  assign tap.update_dr_o        = update_dr_r;
  assign tap.pause_dr_o         = pause_dr_r;
  assign tap.debug_tdi_o        = debug_tdi_r;

endmodule

// File: doc/jtag_tap_oversampled.md
Name: jtag_tap_oversampled

Overview:
- IEEE 1149.1 TAP responder for the JTAG pins driven by the bench's JTAG VPI master.
- The pins are oversampled in the system clock domain, so no tck clock domain exists.
- Drives the 16-state TAP FSM, the 4-bit instruction register, and the IDCODE and BYPASS data registers.
- Exposes shift/capture/update strobes and a serial data path to the debug unit on the DEBUG instruction.
- Sits in orpsoc_top between the tck/tms/tdi/tdo pads and the debug interface.

Parameters:
- IR_WIDTH, 4, instruction register width.
- IDCODE_VALUE, 32'h149511C3, value captured by the IDCODE instruction.
- USERCODE_VALUE, 32'h00000000, value captured by the USERCODE instruction. Used only with the optional feature.

Ports:
- wb_clk_i  in  1  system clock; must run ≥4x tck.
- wb_rst_i  in  1  synchronous active-high reset.
- tck_pad_i  in  1  JTAG clock, asynchronous to wb_clk_i.
- tms_pad_i  in  1  JTAG mode select.
- tdi_pad_i  in  1  JTAG serial in.
- tdo_pad_o  out  1  JTAG serial out.
- tdo_oe_o  out  1  high in Shift-DR/Shift-IR.
- test_logic_reset_o  out  1  high while in Test-Logic-Reset.
- debug_select_o  out  1  high when IR holds DEBUG.
- shift_dr_o / capture_dr_o / update_dr_o  out  1  one-wb_clk_i strobe on the tck rising edge processed in that state.
- pause_dr_o  out  1  high in Pause-DR.
- debug_tdi_o  out  1  registered TDI sample, valid with shift_dr_o.
- debug_tdo_i  in  1  debug unit serial out, muxed to TDO under DEBUG.

Behaviour:
Reset values:
- FSM = Test-Logic-Reset, IR = IDCODE (4'h2).
- tdo_pad_o = 0, tdo_oe_o = 0, test_logic_reset_o = 1.
- All strobes = 0. All synchroniser flops = 0.

Synchroniser and edge detection:
- tck, tms and tdi each pass through a 2-flop synchroniser, followed by a tck_d history flop.
- tck_rise = tck_s & ~tck_d; tck_fall = ~tck_s & tck_d.
- A tck pad edge is acted on in the 3rd wb_clk_i cycle after it. tms and tdi are sampled through the same synchroniser depth, so they stay aligned with tck.

On tck_rise:
- The FSM advances per standard 1149.1 transitions using tms_s.
- Shift-IR: the IR shift register shifts right with tdi_s entering at the MSB.
- Capture-IR: loads 4'b0101.
- Update-IR: copies the shift register into IR.
- Capture-DR: IDCODE → shift reg = IDCODE_VALUE; BYPASS or any undefined code → bypass flop = 0.
- Shift-DR: the selected DR shifts right with tdi_s at the MSB.

On tck_fall:
- tdo_pad_o takes the LSB of the selected register: IR shift reg in Shift-IR, the selected DR in Shift-DR, debug_tdo_i under DEBUG.
- tdo_oe_o follows the state.
- Outside the shift states, tdo_pad_o holds its last value.

Instructions:
- EXTEST 0x0 and SAMPLE_PRELOAD 0x1 decode to BYPASS (no boundary scan).
- IDCODE 0x2, DEBUG 0x8, BYPASS 0xF.
- All other codes behave as BYPASS.

Boundary conditions:
- Five tck rises with tms=1 from any state → Test-Logic-Reset and IR = IDCODE.
- Reset asserted mid-shift → immediate return to reset values, with the partial shift discarded.
- Simultaneous tck_rise and tck_fall cannot occur.
- A tck glitch shorter than 2 wb_clk_i cycles may be missed, by design.

Optional Feature:
- Macro: JTAG_TAP_USERCODE_EN.
- Defined: instruction 0x3 = USERCODE, and Capture-DR loads USERCODE_VALUE into the 32-bit DR.
- Undefined: 0x3 decodes to BYPASS and USERCODE_VALUE is unused.

Decomposition:
- Package jtag_tap_pkg holds:
  - the 4-bit state encoding enum, all 16 states;
  - instruction opcode constants;
  - the IR capture constant 4'b0101.
- One sub-module: jtag_pin_sync, which contains the 2-flop synchronisers and edge detectors and outputs tck_rise, tck_fall, tms_s and tdi_s.

Test Plan:
1. Reset and IDCODE read: release reset, tms=0 then walk to Shift-DR, shift 32 bits → tdo yields 32'h149511C3 LSB-first, tdo_oe_o = 1 only during the shift.
2. IR capture: load IR 0xF and shift out → first 4 tdo bits = 1,0,1,0 (4'b0101 LSB-first).
3. BYPASS: with IR=0xF, shift pattern 0xA5 through DR → tdo reproduces 0xA5 delayed 1 bit, leading bit 0.
4. DEBUG path: with IR=0x8 → debug_select_o = 1. shift_dr_o pulses once per tck in Shift-DR, and debug_tdi_o matches tdi. Tie debug_tdo_i=1 → tdo=1. update_dr_o pulses exactly once.
5. TLR escape: from Shift-DR, 5 tck with tms=1 → test_logic_reset_o = 1 and IR = 0x2. Assert wb_rst_i mid-Shift-IR → all outputs return to reset values the next cycle.
6. USERCODE, with JTAG_TAP_USERCODE_EN: IR=0x3 DR read → USERCODE_VALUE. Without the macro, IR=0x3 → 1-bit bypass.
